// File: rtl/csr_if.sv
// csr_if: CSR request/response bus between the ID-stage decoder and csr_unit
interface csr_if;
  logic [11:0] csr_addr_i;
  logic        csr_read_i;
  logic        csr_write_i;
  logic        csr_op_inv_i;
  logic        csr_no_cal_i;
  logic        csr_zimm_en_i;
  logic [31:0] csr_zimm_i;
  logic [31:0] rs1_data_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  modport master (
    output csr_addr_i, csr_read_i, csr_write_i, csr_op_inv_i, csr_no_cal_i,
           csr_zimm_en_i, csr_zimm_i, rs1_data_i,
    input  csr_rdata_o, csr_illegal_o
  );
  modport slave (
    input  csr_addr_i, csr_read_i, csr_write_i, csr_op_inv_i, csr_no_cal_i,
           csr_zimm_en_i, csr_zimm_i, rs1_data_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with trap state, interrupts and 64-bit counters
// Optional feature: define CSR_VECTORED_EN for vectored mtvec mode.
module csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  csr_if.slave        bus,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  input  logic        instret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif
  logic        r_mie, r_mpie, r_meie, r_mtie, r_meip, r_mtip;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [63:0] r_mcycle, r_minstret;
  logic [31:0] w_mstatus, w_mie, w_mip, w_old, w_src, w_new;
  logic        w_valid, w_illegal, w_we;
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mie     = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip     = {20'b0, r_meip, 3'b0, r_mtip, 7'b0};
  // Old-value read mux; unlisted addresses are unimplemented
  always_comb begin
    w_valid = 1'b1;
    w_old   = '0;
    case (bus.csr_addr_i)
      12'h300: w_old = w_mstatus;
      12'h304: w_old = w_mie;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h344: w_old = w_mip;
      12'hB00: w_old = r_mcycle[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hB02: w_old = r_minstret[31:0];
      12'hB82: w_old = r_minstret[63:32];
      12'hF14: w_old = HART_ID;
      default: w_valid = 1'b0;
    endcase
  end
  assign w_illegal = (bus.csr_read_i | bus.csr_write_i) &
                     (~w_valid | (bus.csr_write_i & (bus.csr_addr_i[11:10] == 2'b11)));
  assign w_src = bus.csr_zimm_en_i ? bus.csr_zimm_i : bus.rs1_data_i;
  assign w_new = bus.csr_no_cal_i ? w_src : bus.csr_op_inv_i ? (w_old & ~w_src) : (w_old | w_src);
  // Trap and mret flush any CSR write issued in the same cycle
  assign w_we  = bus.csr_write_i & ~w_illegal & ~trap_i & ~mret_i;
  assign bus.csr_rdata_o   = (bus.csr_read_i & ~w_illegal) ? w_old : 32'd0;
  assign bus.csr_illegal_o = w_illegal;
  assign mepc_o        = r_mepc;
  assign irq_pending_o = r_mie & ((r_meie & r_meip) | (r_mtie & r_mtip));
`ifdef CSR_VECTORED_EN
  assign trap_vector_o = {r_mtvec[31:2], 2'b00} +
                         ((r_mtvec[0] & trap_cause_i[31]) ? {trap_cause_i[29:0], 2'b00} : 32'd0);
`else
  assign trap_vector_o = r_mtvec;
`endif
  // Trap state, interrupt enables/pending and plain CSR storage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_meip     <= 1'b0;
      r_mtip     <= 1'b0;
      r_mtvec    <= RESET_MTVEC & MTVEC_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      r_meip <= irq_ext_i;
      r_mtip <= irq_timer_i;
      if (trap_i) begin
        r_mepc   <= trap_pc_i & ~32'd1;
        r_mcause <= trap_cause_i;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (mret_i) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_we) begin
        case (bus.csr_addr_i)
          12'h300: begin r_mie <= w_new[3]; r_mpie <= w_new[7]; end
          12'h304: begin r_mtie <= w_new[7]; r_meie <= w_new[11]; end
          12'h305: r_mtvec    <= w_new & MTVEC_MASK;
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= w_new & ~32'd1;
          12'h342: r_mcause   <= w_new;
          default: ;
        endcase
      end
    end
  end
  // Counters: a write to either half replaces it and suppresses that counter's increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_we && bus.csr_addr_i == 12'hB00) r_mcycle[31:0] <= w_new;
      else if (w_we && bus.csr_addr_i == 12'hB80) r_mcycle[63:32] <= w_new;
      else r_mcycle <= r_mcycle + 64'd1;
      if (w_we && bus.csr_addr_i == 12'hB02) r_minstret[31:0] <= w_new;
      else if (w_we && bus.csr_addr_i == 12'hB82) r_minstret[63:32] <= w_new;
      else if (instret_i) r_minstret <= r_minstret + 64'd1;
    end
  end
endmodule
